// File: rtl/ucca_region_ctrl.sv
// UCCA region table, commit lock, region selection and violation reset sequencer.
// Optional macro UCCA_TAMPER_RESET_EN: configuration writes while locked raise a violation.
module ucca_region_ctrl #(
  parameter int          NUM_REGIONS = 4,
  parameter logic [15:0] CONF_BASE   = 16'h0160,
  parameter int          RESET_HOLD  = 4
) (
  input  logic        clk,
  input  logic        system_reset,
  input  logic [15:0] pc,
  input  logic        data_en,
  input  logic        data_wr,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_wdata,
  input  logic        ucca_reset_req,
  output logic [15:0] ucc_min,
  output logic [15:0] ucc_max,
  output logic        ucc_enable,
  output logic [2:0]  ucc_sel,
  output logic        reset_out,
  output logic [7:0]  viol_count
);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_HOLD} state_e;

  localparam logic [15:0] CTRL_OFF  = 16'(4 * NUM_REGIONS);
  localparam logic [3:0]  HOLD_LAST = 4'(RESET_HOLD - 1);

  state_e      state_q, state_d;
  logic [15:0] min_q [NUM_REGIONS];
  logic [15:0] max_q [NUM_REGIONS];
  logic [2:0]  sel_q, sel_d;
  logic [3:0]  hold_q, hold_d;
  logic [7:0]  viol_q, viol_d;

  logic [15:0] cfg_off;
  logic        cfg_wr, entry_wr, ctrl_wr, tamper, viol;
  logic [2:0]  wr_idx;

  // Bus decode: even addresses from CONF_BASE up to and including the control word
  assign cfg_off  = data_addr - CONF_BASE;
  assign cfg_wr   = data_en & data_wr & ~data_addr[0] &
                    (data_addr >= CONF_BASE) & (cfg_off <= CTRL_OFF);
  assign entry_wr = cfg_wr & (cfg_off < CTRL_OFF);
  assign ctrl_wr  = cfg_wr & (cfg_off == CTRL_OFF);
  assign wr_idx   = cfg_off[4:2];

`ifdef UCCA_TAMPER_RESET_EN
  assign tamper = cfg_wr;
`else
  assign tamper = 1'b0;
`endif

  assign viol = (state_q == ST_LOCKED) & (ucca_reset_req | tamper);

  always_ff @(posedge clk) begin
    if (system_reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        min_q[i] <= '0;
        max_q[i] <= '0;
      end
    end else if (entry_wr && state_q == ST_UNLOCKED) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (wr_idx == 3'(i)) begin
          if (cfg_off[1]) max_q[i] <= data_wdata;
          else            min_q[i] <= data_wdata;
        end
      end
    end
  end

  // Region selection: sticky on the current entry, otherwise bypass to the lowest match
  logic [NUM_REGIONS-1:0] hit;
  logic                   match_found, sel_hit;
  logic [2:0]             match_idx, out_idx;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit[i] = (min_q[i] <= max_q[i]) && (max_q[i] != 16'h0000) &&
               (min_q[i] <= pc) && (pc <= max_q[i]);
    end
  end

  always_comb begin
    match_found = 1'b0;
    match_idx   = 3'd0;
    sel_hit     = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        match_found = 1'b1;
        match_idx   = 3'(i);
      end
      if (sel_q == 3'(i)) sel_hit = hit[i];
    end
  end

  always_comb begin
    out_idx = (sel_hit || !match_found) ? sel_q : match_idx;
    sel_d   = out_idx;
    ucc_min = '0;
    ucc_max = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (out_idx == 3'(i)) begin
        ucc_min = min_q[i];
        ucc_max = max_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (system_reset) sel_q <= 3'd0;
    else              sel_q <= sel_d;
  end

  always_ff @(posedge clk) begin
    if (system_reset) state_q <= ST_UNLOCKED;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNLOCKED: if (ctrl_wr && data_wdata[0]) state_d = ST_LOCKED;
      ST_LOCKED:   if (viol)                     state_d = ST_HOLD;
      ST_HOLD:     if (hold_q == 4'd0)           state_d = ST_LOCKED;
      default:                                   state_d = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    ucc_enable = (state_q != ST_UNLOCKED);
    reset_out  = (state_q == ST_HOLD);
  end

  always_comb begin
    hold_d = hold_q;
    viol_d = viol_q;
    if (viol) begin
      hold_d = HOLD_LAST;
      if (viol_q != 8'hFF) viol_d = viol_q + 8'd1;
    end else if (state_q == ST_HOLD && hold_q != 4'd0) begin
      hold_d = hold_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      hold_q <= 4'd0;
      viol_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
      viol_q <= viol_d;
    end
  end

  assign ucc_sel    = sel_q;
  assign viol_count = viol_q;

endmodule

// File: tb/tb_ucca_region_ctrl.sv
// Bench for ucca_region_ctrl: vector table, directed corner sequences, random run vs model.
module tb_ucca_region_ctrl;

  localparam int          NR = 4;
  localparam logic [15:0] CB = 16'h0160;
  localparam int          RH = 4;
`ifdef UCCA_TAMPER_RESET_EN
  localparam bit TAMPER = 1'b1;
`else
  localparam bit TAMPER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        system_reset, data_en, data_wr, ucca_reset_req;
  logic [15:0] pc, data_addr, data_wdata;
  logic [15:0] ucc_min, ucc_max;
  logic        ucc_enable, reset_out;
  logic [2:0]  ucc_sel;
  logic [7:0]  viol_count;

  always #5 clk = ~clk;

  ucca_region_ctrl #(.NUM_REGIONS(NR), .CONF_BASE(CB), .RESET_HOLD(RH)) dut (
    .clk(clk), .system_reset(system_reset), .pc(pc), .data_en(data_en),
    .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .ucca_reset_req(ucca_reset_req), .ucc_min(ucc_min), .ucc_max(ucc_max),
    .ucc_enable(ucc_enable), .ucc_sel(ucc_sel), .reset_out(reset_out),
    .viol_count(viol_count)
  );

  int total = 0;
  int passed = 0;

  // Reference model: plain arrays and counters
  logic [15:0] mmin [NR];
  logic [15:0] mmax [NR];
  bit          locked;
  int          hold_left, cnt, msel;

  typedef struct packed {
    logic        en, wr;
    logic [15:0] addr, wdata, pc;
    logic        req;
    logic [15:0] emin, emax;
    logic [2:0]  esel;
    logic        een, erst;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic en, logic wr, logic [15:0] a, logic [15:0] d,
                              logic [15:0] p, logic rq, logic [15:0] emn, logic [15:0] emx,
                              logic [2:0] es, logic ee, logic er, logic [7:0] ec);
    vec_t v;
    v = '{en, wr, a, d, p, rq, emn, emx, es, ee, er, ec};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit m_hit(int i, logic [15:0] p);
    return (mmin[i] <= mmax[i]) && (mmax[i] != 16'h0) && (mmin[i] <= p) && (p <= mmax[i]);
  endfunction

  function automatic int m_pick(logic [15:0] p);
    if (m_hit(msel, p)) return msel;
    for (int i = 0; i < NR; i++) if (m_hit(i, p)) return i;
    return msel;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mmin[i] = 16'h0;
      mmax[i] = 16'h0;
    end
    locked = 0; hold_left = 0; cnt = 0; msel = 0;
  endtask

  task automatic check_model();
    int k;
    k = m_pick(pc);
    chk("m_min", ucc_min, mmin[k]);
    chk("m_max", ucc_max, mmax[k]);
    chk("m_sel", 16'(ucc_sel), 16'(msel));
    chk("m_en", 16'(ucc_enable), 16'(locked));
    chk("m_rst", 16'(reset_out), 16'(hold_left > 0));
    chk("m_cnt", 16'(viol_count), 16'(cnt));
  endtask

  task automatic model_edge();
    int k, off;
    bit cfg, v;
    k = m_pick(pc);
    if (system_reset) begin
      model_reset();
      return;
    end
    off = int'(data_addr) - int'(CB);
    cfg = data_en && data_wr && !data_addr[0] && off >= 0 && off <= 4 * NR;
    if (!locked) begin
      if (cfg && off < 4 * NR) begin
        if (off % 4 == 2) mmax[off / 4] = data_wdata;
        else              mmin[off / 4] = data_wdata;
      end else if (cfg && data_wdata[0]) begin
        locked = 1;
      end
    end else if (hold_left > 0) begin
      hold_left--;
    end else begin
      v = ucca_reset_req || (TAMPER && cfg);
      if (v) begin
        hold_left = RH;
        if (cnt < 255) cnt++;
      end
    end
    msel = k;
  endtask

  task automatic setin(input logic en, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] p, input logic rq);
    data_en = en; data_wr = wr; data_addr = a; data_wdata = d; pc = p; ucca_reset_req = rq;
  endtask

  task automatic idle(input logic [15:0] p);
    setin(0, 0, 16'h0, 16'h0, p, 0);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    setin(1, 1, a, d, 16'h0, 0);
    cyc();
  endtask

  initial begin
    // Table: program entry0/entry1, commit, priority, stickiness, violation with request in HOLD
    vecs[0]  = mk(1, 1, 16'h0160, 16'hE000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 16'h0162, 16'hE0FF, 16'h0000, 0, 16'hE000, 16'h0000, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 16'h0164, 16'hE080, 16'h0000, 0, 16'hE000, 16'hE0FF, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 16'h0166, 16'hE1FF, 16'h0000, 0, 16'hE000, 16'hE0FF, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 16'h0170, 16'h0001, 16'hE090, 0, 16'hE000, 16'hE0FF, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 16'h0000, 16'hE150, 0, 16'hE080, 16'hE1FF, 0, 1, 0, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 16'h0000, 16'hE0A0, 0, 16'hE080, 16'hE1FF, 1, 1, 0, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 16'hE000, 16'hE0FF, 1, 1, 0, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 16'h0000, 16'hE000, 1, 16'hE000, 16'hE0FF, 0, 1, 0, 0);
    vecs[9]  = mk(0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 16'hE000, 16'hE0FF, 0, 1, 1, 1);
    vecs[10] = mk(0, 0, 16'h0000, 16'h0000, 16'hE000, 1, 16'hE000, 16'hE0FF, 0, 1, 1, 1);
    vecs[11] = mk(0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 16'hE000, 16'hE0FF, 0, 1, 1, 1);
    vecs[12] = mk(0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 16'hE000, 16'hE0FF, 0, 1, 1, 1);
    vecs[13] = mk(0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 16'hE000, 16'hE0FF, 0, 1, 0, 1);

    system_reset = 1'b1;
    idle(16'h0);
    @(posedge clk);
    model_reset();
    #1;
    cyc();
    system_reset = 1'b0;

    @(negedge clk);
    chk("rst_min", ucc_min, 16'h0);
    chk("rst_max", ucc_max, 16'h0);
    chk("rst_sel", 16'(ucc_sel), 16'h0);
    chk("rst_en", 16'(ucc_enable), 16'h0);
    chk("rst_out", 16'(reset_out), 16'h0);
    chk("rst_cnt", 16'(viol_count), 16'h0);
    @(posedge clk);
    model_edge();
    #1;

    for (int i = 0; i < 14; i++) begin
      setin(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].pc, vecs[i].req);
      @(negedge clk);
      chk($sformatf("v%0d_min", i), ucc_min, vecs[i].emin);
      chk($sformatf("v%0d_max", i), ucc_max, vecs[i].emax);
      chk($sformatf("v%0d_sel", i), 16'(ucc_sel), 16'(vecs[i].esel));
      chk($sformatf("v%0d_en", i), 16'(ucc_enable), 16'(vecs[i].een));
      chk($sformatf("v%0d_rst", i), 16'(reset_out), 16'(vecs[i].erst));
      chk($sformatf("v%0d_cnt", i), 16'(viol_count), 16'(vecs[i].ecnt));
      check_model();
      @(posedge clk);
      model_edge();
      #1;
    end

    // Tamper: write CONF_BASE while locked
    setin(1, 1, CB, 16'h1234, 16'hE000, 0);
    cyc();
    idle(16'hE000);
    @(negedge clk);
    chk("tamper_rst", 16'(reset_out), 16'(TAMPER));
    chk("tamper_min", ucc_min, 16'hE000);
    @(posedge clk);
    model_edge();
    #1;
    repeat (5) cyc();
    chk("tamper_cnt", 16'(viol_count), TAMPER ? 16'd2 : 16'd1);
    chk("tamper_min2", ucc_min, 16'hE000);

    // Reset during HOLD cycle 2
    setin(0, 0, 16'h0, 16'h0, 16'hE000, 1);
    cyc();
    idle(16'hE000);
    cyc();
    system_reset = 1'b1;
    cyc();
    system_reset = 1'b0;
    @(negedge clk);
    chk("mid_min", ucc_min, 16'h0);
    chk("mid_max", ucc_max, 16'h0);
    chk("mid_sel", 16'(ucc_sel), 16'h0);
    chk("mid_en", 16'(ucc_enable), 16'h0);
    chk("mid_rst", 16'(reset_out), 16'h0);
    chk("mid_cnt", 16'(viol_count), 16'h0);
    @(posedge clk);
    model_edge();
    #1;

    // Invalid entry (min > max) and request while unlocked
    wr(CB + 16'd8, 16'hF000);
    wr(CB + 16'd10, 16'hE000);
    setin(0, 0, 16'h0, 16'h0, 16'hE800, 1);
    cyc();
    idle(16'hE800);
    @(negedge clk);
    chk("unl_rst", 16'(reset_out), 16'h0);
    chk("unl_cnt", 16'(viol_count), 16'h0);
    @(posedge clk);
    model_edge();
    #1;
    wr(CB + 16'(4 * NR), 16'h0001);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] pv;
      pv = (i == 0) ? 16'hF000 : (i == 1) ? 16'hE800 : (i == 2) ? 16'hE000 : 16'hF800;
      idle(pv);
      @(negedge clk);
      chk("inv_min", ucc_min, 16'h0);
      chk("inv_sel", 16'(ucc_sel), 16'h0);
      @(posedge clk);
      model_edge();
      #1;
    end

    // Saturation: continuous request gives one violation per HOLD+1 cycles
    setin(0, 0, 16'h0, 16'h0, 16'hE000, 1);
    repeat (260 * (RH + 1)) cyc();
    chk("sat_cnt", 16'(viol_count), 16'h00FF);
    repeat (2 * (RH + 1)) cyc();
    chk("sat_hold", 16'(viol_count), 16'h00FF);

    // Random run against the model
    system_reset = 1'b1;
    idle(16'h0);
    cyc();
    system_reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [15:0] a, d;
      r = $urandom_range(0, 199);
      system_reset = (r == 0);
      a = CB + 16'($urandom_range(0, 4 * NR + 3));
      if ($urandom_range(0, 9) == 0) a = 16'($urandom);
      d = 16'hE000 + 16'($urandom_range(0, 16'h03FF));
      if ($urandom_range(0, 9) == 0) d = 16'($urandom_range(0, 1));
      setin(r < 60, $urandom_range(0, 5) != 0, a, d,
            16'hE000 + 16'($urandom_range(0, 16'h03FF)), $urandom_range(0, 19) == 0);
      cyc();
    end
    system_reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ucca_region_ctrl.md
# ucca_region_ctrl

Configuration and violation sequencer for the UCCA protection logic. It holds a table of NUM_REGIONS untrusted-code regions, programmed through memory-mapped data-bus writes. It locks the table on commit and presents the bounds of the region the CPU is executing in as `ucc_min`/`ucc_max` to the region monitor. It also turns a monitor violation request into a fixed-length CPU reset pulse and counts violations.

## Interface
- NUM_REGIONS, 4, number of region entries (1..8)
- CONF_BASE, 16'h0160, byte address of the first configuration word
- RESET_HOLD, 4, cycles `reset_out` is held per violation (1..15)
- clk  in  1  system clock
- system_reset  in  1  power-on reset
  - Synchronous, active-high.
  - The only source that clears lock, table and counter.
- pc  in  16  current program counter
- data_en  in  1  data-bus access strobe
- data_wr  in  1  data-bus write qualifier
- data_addr  in  16  data-bus byte address
- data_wdata  in  16  data-bus write data
- ucca_reset_req  in  1  violation request from the region monitor (return/stack checks)
- ucc_min  out  16  lower bound of the selected region
- ucc_max  out  16  upper bound of the selected region
- ucc_enable  out  1  protection active; 1 only in LOCKED or HOLD
- ucc_sel  out  3  index of the selected region (registered)
- reset_out  out  1  CPU reset from a violation
- viol_count  out  8  saturating violation counter

## Operation
- Register map, word-aligned:
  - Entry i: min at CONF_BASE+4i, max at CONF_BASE+4i+2.
  - Control word at CONF_BASE+4·NUM_REGIONS; bit0 = commit.
  - A write is `data_en & data_wr` with `data_addr` in range.
  - Odd addresses are ignored.
- Entry validity: entry i is valid iff min ≤ max and max ≠ 0. Invalid entries never match.
- FSM states:
  - UNLOCKED (after reset): table writable; `ucc_enable`=0; `ucca_reset_req` ignored.
  - LOCKED: entered on a control write with bit0=1; table read-only.
  - HOLD: entered from LOCKED on a violation; `reset_out`=1 for RESET_HOLD cycles, then back to LOCKED.
  - There is no path from LOCKED back to UNLOCKED except `system_reset`.
- Region selection:
  - `match` = lowest valid i with min_i ≤ pc ≤ max_i.
  - If pc lies inside entry `ucc_sel`, the selection holds (sticky).
  - Otherwise, if `match` exists, the outputs are driven from entry `match` combinationally in the same cycle, and `ucc_sel` ← `match` on the next edge.
  - If nothing matches, the outputs show entry `ucc_sel` unchanged.
  - The bypass guarantees the monitor sees the correct bounds on the first instruction of a region.
- Violation sources, LOCKED only:
  - `ucca_reset_req`=1.
  - A configuration-range write, only when UCCA_TAMPER_RESET_EN is defined.
  - Simultaneous sources count as one violation.
- `viol_count`: +1 per LOCKED→HOLD transition; saturates at 8'hFF.
- Events arriving while in HOLD are dropped: no extension of the pulse, no count.
- Unsigned 16-bit compares throughout; no wrap-around regions (min > max means invalid).

## Timing
- Reset values:
  - `ucc_min`=`ucc_max`=0, `ucc_sel`=0, `ucc_enable`=0, `reset_out`=0, `viol_count`=0.
  - All table entries = 0, so every entry is invalid.
- Table write at edge t is visible to selection from cycle t+1.
- Commit at edge t: `ucc_enable`=1 from t+1.
  - A table write and a commit write cannot coincide; they are single-port bus cycles.
- Violation sampled at edge t: `reset_out`=1 for cycles t+1 … t+RESET_HOLD; LOCKED again at t+RESET_HOLD+1.
- A `system_reset` during HOLD aborts the pulse immediately: `reset_out`=0 the next cycle and the state is UNLOCKED.
- `ucc_min`/`ucc_max` are combinational from the registered table, `ucc_sel` and pc; all other outputs are registered.

## Configuration
- UCCA_TAMPER_RESET_EN
  - Defined: any configuration write while LOCKED or HOLD is a violation; it is sampled and counted only in LOCKED.
  - Undefined: such writes are silently discarded and never raise `reset_out`.
  - The table contents are unchanged in both cases.

## Test plan
- Bring-up:
  - Stimulus: write entry0 = 16'hE000/16'hE0FF, commit.
  - Check: `ucc_enable`=1 one cycle after the commit edge.
  - Check: pc=16'hE000 gives `ucc_min`=16'hE000 in the same cycle and `ucc_sel`=0.
- Priority and stickiness:
  - Stimulus: entry0 = E000–E0FF, entry1 = E080–E1FF; pc E090, then E150, then E0A0.
  - Check: sel = 0, then 1, then 1 (sticky).
- Violation:
  - Stimulus: LOCKED; one-cycle `ucca_reset_req`.
  - Check: `reset_out` high for exactly 4 cycles; `viol_count`=1.
  - Check: a second request inside HOLD produces no extra cycles and no count.
- Tamper with macro:
  - Stimulus: LOCKED; write CONF_BASE=16'h1234.
  - Check: with UCCA_TAMPER_RESET_EN, a HOLD pulse, count+1, table unchanged.
  - Check: without the macro, no pulse, table unchanged.
- Invalid entries and unlocked behaviour:
  - Stimulus: entry with min=16'hF000, max=16'hE000.
  - Check: the entry never matches.
  - Stimulus: `ucca_reset_req` while UNLOCKED.
  - Check: no `reset_out`.
- Saturation and reset mid-HOLD:
  - Stimulus: 256 violations.
  - Check: `viol_count`=16'hFF stays 8'hFF.
  - Stimulus: `system_reset` in HOLD cycle 2.
  - Check: all outputs return to their reset values next cycle.
